// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared constants for the RV32 ALU control block: 4-bit ALU
//               operation encodings, RV32M funct3 codes and the state type
//               of the iterative multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation select driven to the datapath
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    // RV32M funct3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Multiply/divide engine state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative RV32M engine. Shift-add multiply and restoring
//               divide, one bit per clock on magnitudes, signs re-applied on
//               the final step. Divide-by-zero and signed overflow finish in
//               a single clock.
// Ports       : clk_i, rst_ni          clock, async active-low reset
//               start_i                M-op presented this cycle
//               funct3_i               M-op select
//               src_a_i, src_b_i       operands
//               in_ready_o             engine idle, will accept start_i
//               out_valid_o            result_o valid (held until taken)
//               out_ready_i            consumer takes result_o
//               result_o               M-op result
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            in_ready_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*XLEN-1:0]  acc_q;     // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic [XLEN-1:0]    opd_q;     // multiplicand (MUL) or divisor (DIV) magnitude
    logic               neg_q;     // product / quotient sign
    logic               sa_q;      // remainder sign follows the dividend
    logic [2:0]         f3_q;
    logic [XLEN-1:0]    result_q;

    // ---------------- accept-time decode ----------------
    logic            accept;
    logic            is_div;
    logic            a_signed, b_signed;
    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign accept   = start_i & (state_q == ST_IDLE);
    assign is_div   = funct3_i[2];
    // MUL/MULH/MULHSU treat rs1 as signed, only MUL/MULH treat rs2 as signed;
    // DIV/REM (funct3[0]=0) are signed on both operands.
    assign a_signed = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign b_signed = is_div ? ~funct3_i[0] : ~funct3_i[1];
    assign sa       = a_signed & src_a_i[XLEN-1];
    assign sb       = b_signed & src_b_i[XLEN-1];
    assign mag_a    = sa ? (~src_a_i + 1'b1) : src_a_i;
    assign mag_b    = sb ? (~src_b_i + 1'b1) : src_b_i;

    assign div_zero = is_div & (src_b_i == '0);
    assign div_ovf  = is_div & ~funct3_i[0]
                    & (src_a_i == {1'b1, {(XLEN-1){1'b0}}})
                    & (src_b_i == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3_i[1] ? src_a_i : '1;
        end else if (div_ovf) begin
            special_res = funct3_i[1] ? '0 : src_a_i;
        end
    end

    // ---------------- iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   mul_res, div_res;
    logic              last;

    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole accumulator right with the carry.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: trial-subtract the divisor from the remainder shifted
    // left by one dividend bit; a borrow keeps the shifted remainder.
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
    assign div_acc  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod    = neg_q ? (~mul_acc + 1'b1) : mul_acc;
    assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign quo     = div_acc[XLEN-1:0];
    assign rem     = div_acc[2*XLEN-1:XLEN];
    assign div_res = (f3_q[1])
                   ? (sa_q  ? (~rem + 1'b1) : rem)
                   : (neg_q ? (~quo + 1'b1) : quo);

    assign last = (cnt_q == CNT_W'(XLEN - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (special)     state_d = ST_DONE;
                    else if (is_div) state_d = ST_DIV;
                    else             state_d = ST_MUL;
                end
            end
            ST_MUL:  if (last)        state_d = ST_DONE;
            ST_DIV:  if (last)        state_d = ST_DONE;
            ST_DONE: if (out_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_o  = (state_q == ST_IDLE);
        out_valid_o = (state_q == ST_DONE);
    end

    assign result_o = result_q;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            f3_q     <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                f3_q  <= funct3_i;
                cnt_q <= '0;
                neg_q <= sa ^ sb;
                sa_q  <= sa;
                if (is_div) begin
                    opd_q <= mag_b;
                    acc_q <= {{XLEN{1'b0}}, mag_a};
                end else begin
                    opd_q <= mag_a;
                    acc_q <= {{XLEN{1'b0}}, mag_b};
                end
                if (special) begin
                    result_q <= special_res;
                end
            end else if (state_q == ST_MUL) begin
                acc_q <= mul_acc;
                cnt_q <= cnt_q + 1'b1;
                if (last) result_q <= mul_res;
            end else if (state_q == ST_DIV) begin
                acc_q <= div_acc;
                cnt_q <= cnt_q + 1'b1;
                if (last) result_q <= div_res;
            end
        end
    end

endmodule : muldiv_iter
`default_nettype wire

// File: rtl/alu_decode_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_muldiv
// Description : ALU control decoder for the RV32 single-cycle core with an
//               attached iterative RV32M multiply/divide engine.
// Ports       : clk, rst_n                      clock, async active-low reset
//               alu_op, funct3, funct7_5,
//               funct7_0, op5                   decode inputs from main decoder
//               src_a, src_b                    rs1 / rs2 values
//               in_valid                        instruction valid this cycle
//               in_ready                        engine can accept an M-op
//               alu_control                     4-bit ALU operation select
//               is_md                           current instruction is an M-op
//               md_result, out_valid, out_ready M-op result handshake
//               stall                           hold PC / instruction
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            op5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [3:0]      alu_control,
    output logic            is_md,
    output logic [XLEN-1:0] md_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            stall
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    assign is_md = (alu_op == 2'b10) & op5 & funct7_0 & in_valid;

    // The core advances in the same cycle the result is taken.
    assign stall = is_md & ~(out_valid & out_ready);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b00: alu_control = ALU_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: alu_control = ALU_SUB;   // beq / bne
                    3'b100, 3'b101: alu_control = ALU_SLT;   // blt / bge
                    3'b110, 3'b111: alu_control = ALU_SLTU;  // bltu / bgeu
                    default:        alu_control = ALU_ADD;
                endcase
            end
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    // srai carries funct7_5 in imm[10], so no op5 qualifier
                    3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
        if (is_md) begin
            alu_control = ALU_NOP;
        end
    end

    muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv_iter (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (is_md),
        .funct3_i    (funct3),
        .src_a_i     (src_a),
        .src_b_i     (src_b),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (md_result)
    );

endmodule : alu_decode_muldiv
`default_nettype wire

// File: tb/tb_alu_decode_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_decode_muldiv
// Description : Self-checking bench for alu_decode_muldiv. Decoder sweep
//               against the control table, M-op results through a scoreboard
//               queue, latency, back-pressure and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_decode_muldiv;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            funct7_0;
    logic            op5;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic            is_md;
    logic [XLEN-1:0] md_result;
    logic            out_valid;
    logic            out_ready;
    logic            stall;

    int n_chk;
    int n_err;
    logic [31:0] sb_q[$];

    alu_decode_muldiv #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .funct7_0    (funct7_0),
        .op5         (op5),
        .src_a       (src_a),
        .src_b       (src_b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .is_md       (is_md),
        .md_result   (md_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference control table
    function automatic logic [3:0] exp_ctl(input int op, input int f3, input bit o5, input bit f75);
        logic [3:0] r;
        r = 4'h0;
        if (op == 1) begin
            case (f3)
                0, 1:    r = 4'h1;
                4, 5:    r = 4'h3;
                6, 7:    r = 4'h4;
                default: r = 4'h0;
            endcase
        end else if (op == 2) begin
            case (f3)
                0:       r = (o5 && f75) ? 4'h1 : 4'h0;
                1:       r = 4'h2;
                2:       r = 4'h3;
                3:       r = 4'h4;
                4:       r = 4'h5;
                5:       r = f75 ? 4'h7 : 4'h6;
                6:       r = 4'h8;
                default: r = 4'h9;
            endcase
        end
        return r;
    endfunction

    // Issue one M-op, wait for the result and retire it. lat is the number of
    // clock edges after the accept edge until out_valid; hold is the number
    // of DONE cycles with out_ready low before the result is taken.
    task automatic run_md(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold);
        int  n;
        bit  stall_ok;
        logic [31:0] e;
        alu_op    = 2'b10;
        op5       = 1'b1;
        funct7_0  = 1'b1;
        funct7_5  = 1'b0;
        funct3    = f3;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        #1;
        chk({tag, "_is_md"}, is_md, 1);
        chk({tag, "_nop"}, alu_control, 4'hF);
        chk({tag, "_ready"}, in_ready, 1);
        sb_q.push_back(exp);
        tick();                              // accept edge
        n = 0;
        stall_ok = 1'b1;
        while (!out_valid && n < 40) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_stall_busy"}, stall_ok, 1);
        if (!out_valid) begin
            chk({tag, "_timeout"}, out_valid, 1);
            in_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_result"}, md_result, sb_q[0]);
            chk({tag, "_hold_ready"}, in_ready, 0);
            chk({tag, "_hold_stall"}, stall, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk({tag, "_stall_release"}, stall, 0);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_scoreboard_empty"}, 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk({tag, "_result"}, md_result, e);
            end
        end
        tick();
        chk({tag, "_idle_ready"}, in_ready, 1);
        chk({tag, "_idle_valid"}, out_valid, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        alu_op    = 2'b00;
        funct3    = 3'b000;
        funct7_5  = 1'b0;
        funct7_0  = 1'b0;
        op5       = 1'b0;
        src_a     = '0;
        src_b     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_md_result", md_result, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Decoder sweep (non-M instructions)
        for (int op = 0; op < 4; op++) begin
            for (int f3 = 0; f3 < 8; f3++) begin
                for (int o5 = 0; o5 < 2; o5++) begin
                    for (int f75 = 0; f75 < 2; f75++) begin
                        alu_op   = 2'(op);
                        funct3   = 3'(f3);
                        op5      = 1'(o5);
                        funct7_5 = 1'(f75);
                        funct7_0 = 1'b0;
                        in_valid = 1'b1;
                        #1;
                        chk($sformatf("dec_op%0d_f3%0d_o5%0d_f7%0d", op, f3, o5, f75),
                            alu_control, exp_ctl(op, f3, o5 != 0, f75 != 0));
                    end
                end
            end
        end
        chk("dec_no_md_ready", in_ready, 1);

        // Spot checks
        alu_op = 2'b10; funct3 = 3'b101; funct7_5 = 1'b1; op5 = 1'b0; funct7_0 = 1'b0;
        #1;
        chk("spot_srai", alu_control, 4'b0111);
        alu_op = 2'b01; funct3 = 3'b110; funct7_5 = 1'b0;
        #1;
        chk("spot_bltu", alu_control, 4'b0100);

        // M-flag patterns that must not count as an M-op
        alu_op = 2'b10; funct3 = 3'b100; op5 = 1'b1; funct7_0 = 1'b1; funct7_5 = 1'b0; in_valid = 1'b0;
        #1;
        chk("md_invalid_is_md", is_md, 0);
        chk("md_invalid_ctl", alu_control, 4'b0101);
        alu_op = 2'b00; in_valid = 1'b1;
        #1;
        chk("md_aluop00_is_md", is_md, 0);
        chk("md_aluop00_ctl", alu_control, 4'b0000);
        alu_op = 2'b10; op5 = 1'b0;
        #1;
        chk("md_itype_is_md", is_md, 0);
        in_valid = 1'b0;
        tick();
        chk("md_none_ready", in_ready, 1);

        // Multiply / divide
        run_md("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 0);
        run_md("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 0);
        run_md("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32, 0);
        run_md("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0);
        run_md("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32, 0);
        run_md("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32, 0);
        run_md("divu",   3'b101, 32'd100,       32'd7,         32'd14,        32, 0);
        run_md("divu0",  3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 0,  0);
        run_md("remu0",  3'b111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 0,  0);
        run_md("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  0);
        run_md("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0,  0);
        run_md("remu_hold", 3'b111, 32'd100,    32'd7,         32'd2,         32, 5);

        // Asynchronous reset in the middle of a divide
        alu_op = 2'b10; op5 = 1'b1; funct7_0 = 1'b1; funct7_5 = 1'b0;
        funct3 = 3'b100; src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();                              // accept
        in_valid = 1'b0;
        chk("arst_busy", in_ready, 0);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_md_result", md_result, 0);
        tick();
        rst_n = 1'b1;
        #1;
        run_md("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 32, 0);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_alu_decode_muldiv
`default_nettype wire
